extal_gen: RTL and testbench

- Parametrised CPU clock generator driving the Z8S180 EXTAL pin from hwclk.
- Successor to the fixed free-running divide-by-2^22 counter; adds a runtime-selectable divide ratio, glitch-free ratio changes, halt/run/single-step modes and a debounced step button.
- Sits in the board top level between hwclk and the extal output pin.
- Feeds extal_rise and cycle_count to LED/test-point logic.

---
 rtl/extal_gen_pkg.sv | 14 +
 rtl/step_debounce.sv | 48 ++++
 rtl/extal_gen.sv | 121 ++++++++++++
 tb/tb_extal_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/extal_gen_pkg.sv
// Shared encodings for the EXTAL clock generator: operating modes and FSM states.
// Constants only; no latency or backpressure of its own.
package extal_gen_pkg;
  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  localparam mode_t MODE_HALT = 2'b00;
  localparam mode_t MODE_RUN  = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_HIGH = 2'b01;
  localparam state_t ST_LOW  = 2'b10;
endpackage

// File: rtl/step_debounce.sv
// Step button conditioner: 2-FF synchroniser, then a 2^DEBOUNCE_BITS stability filter.
// Latency 2^DEBOUNCE_BITS+3 cycles; emits a one-cycle press pulse, no backpressure.
module step_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic hwclk,
  input  logic reset_n,
  input  logic step_n,
  output logic press
);
  logic sync1_q, sync2_q;
  logic stable_q, stable_d;
  logic press_q, press_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

  // Any return to the stable level restarts the stability window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (&cnt_q) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= step_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/extal_gen.sv
// Z8S180 EXTAL generator: period 2*2^div_sel hwclk, first edge 1 cycle after RUN, no backpressure.
// Optional rising-edge counter enabled by EXTAL_GEN_CYCLE_COUNT_EN; otherwise cycle_count is 0.
module extal_gen
  import extal_gen_pkg::*;
#(
  parameter int CTR_BITS      = 24,
  parameter int DEBOUNCE_BITS = 16,
  parameter int COUNT_BITS    = 16
) (
  input  logic                  hwclk,
  input  logic                  reset_n,
  input  logic [4:0]            div_sel,
  input  logic [1:0]            mode,
  input  logic                  step_n,
  output logic                  extal,
  output logic                  extal_rise,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] cycle_count
);
  localparam logic [4:0] MAX_SEL = 5'(CTR_BITS - 1);

  state_t              state_q, state_d;
  logic [CTR_BITS-1:0] timer_q, timer_d;
  logic [CTR_BITS-1:0] reload_q, reload_d;
  logic                pend_q, pend_d;
  logic                extal_q, extal_rise_q;
  logic                press, go, enter_high;
  logic [4:0]          sel;
  logic [CTR_BITS-1:0] h_m1;

  step_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_step (
    .hwclk   (hwclk),
    .reset_n (reset_n),
    .step_n  (step_n),
    .press   (press)
  );

  assign sel  = (div_sel > MAX_SEL) ? MAX_SEL : div_sel;
  assign h_m1 = (CTR_BITS'(1) << sel) - CTR_BITS'(1);
  assign go   = (mode == MODE_RUN) || ((mode == MODE_STEP) && pend_q);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    enter_high = 1'b0;
    case (state_q)
      ST_IDLE: enter_high = go;
      ST_HIGH: begin
        if (timer_q == '0) begin
          state_d = ST_LOW;
          timer_d = reload_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (timer_q == '0) begin
          enter_high = go;
          if (!go) state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // div_sel is captured only here, so every period stays symmetric.
    if (enter_high) begin
      state_d  = ST_HIGH;
      timer_d  = h_m1;
      reload_d = h_m1;
    end
  end

  // Single-entry queue; a STEP-mode entry consumes it, presses outside STEP are ignored.
  always_comb begin
    pend_d = pend_q;
    if (enter_high && (mode == MODE_STEP)) pend_d = 1'b0;
    else if (press && (mode == MODE_STEP)) pend_d = 1'b1;
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      reload_q     <= '0;
      pend_q       <= 1'b0;
      extal_q      <= 1'b0;
      extal_rise_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      reload_q     <= reload_d;
      pend_q       <= pend_d;
      extal_q      <= (state_d == ST_HIGH);
      extal_rise_q <= enter_high;
    end
  end

`ifdef EXTAL_GEN_CYCLE_COUNT_EN
  logic [COUNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enter_high) count_d = count_q + 1'b1;
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

  assign extal      = extal_q;
  assign extal_rise = extal_rise_q;
  assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_extal_gen.sv
// Directed bench for extal_gen: CTR_BITS=8, DEBOUNCE_BITS=4, COUNT_BITS=4.
// Inputs change and outputs are sampled 1 ns after each rising hwclk edge.
`timescale 1ns/1ps
module tb_extal_gen;
  import extal_gen_pkg::*;

  localparam int CB   = 8;
  localparam int CNTB = 4;
`ifdef EXTAL_GEN_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            hwclk   = 1'b0;
  logic            reset_n = 1'b0;
  logic            step_n  = 1'b1;
  logic [4:0]      div_sel = 5'd0;
  logic [1:0]      mode    = MODE_HALT;
  logic            extal, extal_rise, busy;
  logic [CNTB-1:0] cycle_count;

  int total = 0;
  int bad   = 0;
  int n_rise = 0, n_high = 0, n_busy = 0;

  extal_gen #(.CTR_BITS(CB), .DEBOUNCE_BITS(4), .COUNT_BITS(CNTB)) dut (
    .hwclk       (hwclk),
    .reset_n     (reset_n),
    .div_sel     (div_sel),
    .mode        (mode),
    .step_n      (step_n),
    .extal       (extal),
    .extal_rise  (extal_rise),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  always #5 hwclk = ~hwclk;

  always @(negedge hwclk) begin
    if (extal_rise) n_rise++;
    if (extal)      n_high++;
    if (busy)       n_busy++;
  end

  function automatic logic [CNTB-1:0] exp_cnt(input int k);
    return CNT_EN ? CNTB'(k) : '0;
  endfunction

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [4:0] d);
    reset_n = 1'b0;
    mode    = m;
    div_sel = d;
    step_n  = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic press_btn(input int low_cycles, input int high_cycles);
    step_n = 1'b0;
    repeat (low_cycles) tick();
    step_n = 1'b1;
    repeat (high_cycles) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = MODE_RUN; div_sel = 5'd2;
    repeat (2) tick();
    total++; if (extal !== 1'b0) begin bad++; $display("FAIL reset_extal got=%b want=0", extal); end
    total++; if (extal_rise !== 1'b0) begin bad++; $display("FAIL reset_rise got=%b want=0", extal_rise); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cycle_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
    reset_n = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      total++;
      if (extal !== ((i % 8) < 4)) begin bad++; $display("FAIL run2_extal i=%0d got=%b want=%b", i, extal, ((i % 8) < 4)); end
      total++;
      if (extal_rise !== ((i % 8) == 0)) begin bad++; $display("FAIL run2_rise i=%0d got=%b want=%b", i, extal_rise, ((i % 8) == 0)); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run2_busy got=%b want=1", busy); end
    total++; if (cycle_count !== exp_cnt(3)) begin bad++; $display("FAIL run2_count got=%0d want=%0d", cycle_count, exp_cnt(3)); end
  endtask

  task automatic test_div_change();
    logic exp_e;
    do_reset(MODE_RUN, 5'd0);
    for (int i = 0; i <= 4; i++) begin
      tick();
      total++;
      if (extal !== ((i % 2) == 0)) begin bad++; $display("FAIL div0_extal i=%0d got=%b want=%b", i, extal, ((i % 2) == 0)); end
    end
    div_sel = 5'd3;
    for (int j = 1; j <= 18; j++) begin
      tick();
      exp_e = (j >= 2 && j <= 9) || (j == 18);
      total++;
      if (extal !== exp_e) begin bad++; $display("FAIL divchg_extal j=%0d got=%b want=%b", j, extal, exp_e); end
      total++;
      if (extal_rise !== (j == 2 || j == 18)) begin bad++; $display("FAIL divchg_rise j=%0d got=%b want=%b", j, extal_rise, (j == 2 || j == 18)); end
    end
  endtask

  task automatic test_step();
    int r0, h0, b0;
    do_reset(MODE_STEP, 5'd1);
    repeat (5) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL step_idle_busy got=%b want=0", busy); end
    r0 = n_rise;
    press_btn(5, 30);
    total++; if (n_rise - r0 !== 0) begin bad++; $display("FAIL step_bounce_rises got=%0d want=0", n_rise - r0); end
    r0 = n_rise; h0 = n_high; b0 = n_busy;
    press_btn(20, 30);
    total++; if (n_rise - r0 !== 1) begin bad++; $display("FAIL step_rises got=%0d want=1", n_rise - r0); end
    total++; if (n_high - h0 !== 2) begin bad++; $display("FAIL step_high_cycles got=%0d want=2", n_high - h0); end
    total++; if (n_busy - b0 !== 4) begin bad++; $display("FAIL step_busy_cycles got=%0d want=4", n_busy - b0); end
    total++; if (busy !== 1'b0 || extal !== 1'b0) begin bad++; $display("FAIL step_end busy=%b extal=%b want 0 0", busy, extal); end
  endtask

  task automatic test_queue();
    int r0, h0;
    do_reset(MODE_STEP, 5'd6);
    r0 = n_rise; h0 = n_high;
    press_btn(20, 20);
    press_btn(20, 20);
    press_btn(20, 20);
    repeat (200) tick();
    total++; if (n_rise - r0 !== 2) begin bad++; $display("FAIL queue_rises got=%0d want=2", n_rise - r0); end
    total++; if (n_high - h0 !== 128) begin bad++; $display("FAIL queue_high_cycles got=%0d want=128", n_high - h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL queue_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_halt();
    do_reset(MODE_RUN, 5'd4);
    tick();
    total++; if (extal !== 1'b1) begin bad++; $display("FAIL halt_first_edge got=%b want=1", extal); end
    repeat (5) tick();
    mode = MODE_HALT;
    for (int i = 6; i <= 40; i++) begin
      tick();
      total++;
      if (extal !== (i <= 15)) begin bad++; $display("FAIL halt_extal i=%0d got=%b want=%b", i, extal, (i <= 15)); end
      total++;
      if (busy !== (i <= 31)) begin bad++; $display("FAIL halt_busy i=%0d got=%b want=%b", i, busy, (i <= 31)); end
    end
  endtask

  task automatic test_reserved();
    int r0;
    r0 = n_rise;
    do_reset(2'b11, 5'd0);
    repeat (6) tick();
    total++; if (busy !== 1'b0 || n_rise - r0 !== 0) begin bad++; $display("FAIL reserved busy=%b rises=%0d want 0 0", busy, n_rise - r0); end
  endtask

  task automatic test_clamp();
    do_reset(MODE_RUN, 5'd31);
    tick();
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 127) begin
        total++; if (extal !== 1'b1) begin bad++; $display("FAIL clamp_high_end got=%b want=1", extal); end
      end
      if (i == 128) begin
        total++; if (extal !== 1'b0) begin bad++; $display("FAIL clamp_low_start got=%b want=0", extal); end
      end
      if (i == 256) begin
        total++; if (extal_rise !== 1'b1) begin bad++; $display("FAIL clamp_next_rise got=%b want=1", extal_rise); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(MODE_RUN, 5'd4);
    repeat (4) tick();
    total++; if (extal !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", extal); end
    reset_n = 1'b0;
    #1;
    total++; if (extal !== 1'b0) begin bad++; $display("FAIL rstmid_extal got=%b want=0", extal); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (cycle_count !== '0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", cycle_count); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset(MODE_RUN, 5'd0);
    for (int i = 0; i <= 30; i++) begin
      tick();
      if (i == 0 || i == 14 || i == 30) begin
        total++;
        if (cycle_count !== exp_cnt(i / 2 + 1)) begin
          bad++; $display("FAIL wrap_count i=%0d got=%0d want=%0d", i, cycle_count, exp_cnt(i / 2 + 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div_change();
    test_step();
    test_queue();
    test_halt();
    test_reserved();
    test_clamp();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
